// File: rtl/spi_master.sv
// SPI master: one start pulse runs one LSB-first full-duplex word transfer.
// SCK is CLK_DIV system clocks per half-period; all outputs are registered.
module spi_master #(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned CLK_DIV     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] data_in,
    input  logic                   MISO,
    output logic                   SS,
    output logic                   SCK,
    output logic                   MOSI,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EW = $clog2(2 * DATA_LENGTH);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_LENGTH - 1);
    localparam logic          IDLE_SCK  = 1'(CPOL);
    localparam logic          PHA       = (CPHA != 0);

    typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StGap} state_e;

    state_e                 state_q, state_d;
    logic [DW-1:0]          div_q, div_d;
    logic [EW-1:0]          edge_q, edge_d;
    logic [DATA_LENGTH-1:0] tx_q, tx_d;
    logic [DATA_LENGTH-1:0] rx_q, rx_d;
    logic                   ss_q, ss_d;
    logic                   sck_q, sck_d;
    logic                   mosi_q, mosi_d;
    logic [DATA_LENGTH-1:0] data_out_q, data_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   div_wrap;
    logic                   edge_fire;
    logic [EW-1:0]          edge_idx;
    logic                   is_leading;
    logic                   is_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            ss_q       <= 1'b1;
            sck_q      <= IDLE_SCK;
            mosi_q     <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            ss_q       <= ss_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        ss_d       = ss_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        edge_fire  = 1'b0;
        edge_idx   = edge_q;
        div_wrap   = (div_q == DIV_LAST);

        case (state_q)
            StIdle: begin
                ss_d   = 1'b1;
                sck_d  = IDLE_SCK;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                div_d  = '0;
                edge_d = '0;
                if (start) begin
                    rx_d    = '0;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StSetup;
                    // CPHA=0 presents bit 0 before the first edge, so tx holds the rest
                    if (PHA) begin
                        tx_d   = data_in;
                        mosi_d = 1'b0;
                    end else begin
                        tx_d   = data_in >> 1;
                        mosi_d = data_in[0];
                    end
                end
            end
            StSetup: begin
                if (div_wrap) begin
                    div_d     = '0;
                    edge_d    = '0;
                    edge_idx  = '0;
                    edge_fire = 1'b1;
                    sck_d     = ~sck_q;
                    state_d   = StXfer;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StXfer: begin
                if (div_wrap) begin
                    div_d = '0;
                    if (edge_q == EDGE_LAST) begin
                        sck_d   = IDLE_SCK;
                        state_d = StHold;
                    end else begin
                        edge_idx  = edge_q + 1'b1;
                        edge_d    = edge_idx;
                        edge_fire = 1'b1;
                        sck_d     = ~sck_q;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StHold: begin
                if (div_wrap) begin
                    div_d      = '0;
                    ss_d       = 1'b1;
                    data_out_d = rx_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = StGap;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StGap: begin
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Even edge indices move SCK away from its idle level
        is_leading = ~edge_idx[0];
        is_sample  = PHA ? ~is_leading : is_leading;
        if (edge_fire) begin
            if (is_sample) begin
                rx_d = {MISO, rx_q[DATA_LENGTH-1:1]};
            end else if (PHA || (edge_idx != EDGE_LAST)) begin
                mosi_d = tx_q[0];
                tx_d   = tx_q >> 1;
            end
        end
    end

    assign SS       = ss_q;
    assign SCK      = sck_q;
    assign MOSI     = mosi_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: five instances covering all SPI modes and two dividers,
// each with a loopback, behavioural-slave or constant-high MISO source.
module tb_spi_master;

    localparam int N = 5;
    // instance: 0 mode00 div2, 1 mode01, 2 mode10, 3 mode11, 4 mode00 div4
    localparam logic [4:0] CPOL_V = 5'b01100;
    localparam logic [4:0] CPHA_V = 5'b01010;

    logic          clk;
    logic          rst;
    logic [N-1:0]  start_v;
    logic [N-1:0]  miso_v;
    logic [N-1:0]  ss_v;
    logic [N-1:0]  sck_v;
    logic [N-1:0]  mosi_v;
    logic [N-1:0]  busy_v;
    logic [N-1:0]  done_v;
    logic [N*8-1:0] din_f;
    logic [N*8-1:0] dout_f;
    logic [N*8-1:0] sdin_f;
    logic [N*8-1:0] sdout_f;
    logic [N*2-1:0] mm_f;   // 0 loopback, 1 slave model, 2 constant 1

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        localparam int unsigned CD = (g == 4) ? 4 : 2;

        logic       sck_p, ss_p, s_miso, lead, smp;
        logic [7:0] s_tx, s_rx, s_dout;

        spi_master #(
            .DATA_LENGTH(8),
            .CPOL       (CPOL_V[g]),
            .CPHA       (CPHA_V[g]),
            .CLK_DIV    (CD)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[g]),
            .data_in (din_f[g*8 +: 8]),
            .MISO    (miso_v[g]),
            .SS      (ss_v[g]),
            .SCK     (sck_v[g]),
            .MOSI    (mosi_v[g]),
            .data_out(dout_f[g*8 +: 8]),
            .busy    (busy_v[g]),
            .done    (done_v[g])
        );

        // Slave reacts one clk after each SCK edge it sees
        assign lead = (sck_v[g] != CPOL_V[g]);
        assign smp  = CPHA_V[g] ? !lead : lead;
        always @(posedge clk) begin
            if (rst) begin
                sck_p  <= CPOL_V[g];
                ss_p   <= 1'b1;
                s_miso <= 1'b0;
                s_tx   <= 8'h00;
                s_rx   <= 8'h00;
                s_dout <= 8'h00;
            end else begin
                sck_p <= sck_v[g];
                ss_p  <= ss_v[g];
                if (!ss_v[g] && ss_p) begin
                    s_rx <= 8'h00;
                    if (CPHA_V[g]) begin
                        s_tx   <= sdin_f[g*8 +: 8];
                        s_miso <= 1'b0;
                    end else begin
                        s_tx   <= sdin_f[g*8 +: 8] >> 1;
                        s_miso <= sdin_f[g*8];
                    end
                end else if (!ss_v[g] && (sck_v[g] != sck_p)) begin
                    if (smp) begin
                        s_rx <= {mosi_v[g], s_rx[7:1]};
                    end else begin
                        s_miso <= s_tx[0];
                        s_tx   <= s_tx >> 1;
                    end
                end
                if (ss_v[g] && !ss_p) s_dout <= s_rx;
            end
        end

        assign sdout_f[g*8 +: 8] = s_dout;
        assign miso_v[g] = (mm_f[g*2 +: 2] == 2'd0) ? mosi_v[g] :
                           (mm_f[g*2 +: 2] == 2'd1) ? s_miso : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One start pulse on instance i; measures latency, SCK edges, SS-low cycles
    task automatic xfer(input int i, input logic [7:0] tx, input logic [7:0] stx,
                        output int lat, output int edges, output int sslow,
                        output bit glitch, output bit timeout);
        int  n;
        logic psck, pss;
        lat = 0; edges = 0; sslow = 0; glitch = 0; timeout = 1;
        @(negedge clk);
        din_f[i*8 +: 8]  = tx;
        sdin_f[i*8 +: 8] = stx;
        start_v[i]       = 1'b1;
        n    = cyc;
        psck = sck_v[i];
        pss  = ss_v[i];
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (k == 0) start_v[i] = 1'b0;
            if (!ss_v[i]) sslow++;
            if (sck_v[i] != psck && (ss_v[i] || pss)) glitch = 1;
            if (ss_v[i] != pss && (sck_v[i] != CPOL_V[i] || psck != CPOL_V[i])) glitch = 1;
            if (sck_v[i] != psck) edges++;
            psck = sck_v[i];
            pss  = ss_v[i];
            if (done_v[i]) begin
                lat     = cyc - n;
                timeout = 0;
                break;
            end
        end
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        int         idx;
        logic [1:0] mm;
        logic [7:0] tx;
        logic [7:0] stx;
        logic [7:0] exp_d;
        logic [7:0] exp_s;
        bit         chk_s;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   lat, edges, sslow, gap, cnt;
        bit   glitch, timeout, got, saw_done;
        logic psck;

        vecs[0] = '{0, 2'd0, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 37};
        vecs[1] = '{0, 2'd1, 8'hC3, 8'h3C, 8'h3C, 8'hC3, 1'b1, 37};
        vecs[2] = '{1, 2'd1, 8'h81, 8'h7E, 8'h7E, 8'h81, 1'b1, 37};
        vecs[3] = '{2, 2'd1, 8'h81, 8'h7E, 8'h7E, 8'h81, 1'b1, 37};
        vecs[4] = '{3, 2'd1, 8'h81, 8'h7E, 8'h7E, 8'h81, 1'b1, 37};
        vecs[5] = '{1, 2'd1, 8'h7E, 8'h81, 8'h81, 8'h7E, 1'b1, 37};
        vecs[6] = '{4, 2'd2, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 73};
        vecs[7] = '{3, 2'd0, 8'h5A, 8'h00, 8'h5A, 8'h00, 1'b0, 37};

        clk = 1'b0; rst = 1'b1;
        start_v = '0; din_f = '0; sdin_f = '0; mm_f = '0;
        repeat (4) @(negedge clk);
        check("reset_ss",    32'(ss_v),   32'h1F);
        check("reset_sck",   32'(sck_v),  32'(CPOL_V));
        check("reset_mosi",  32'(mosi_v), 32'h0);
        check("reset_busy",  32'(busy_v), 32'h0);
        check("reset_done",  32'(done_v), 32'h0);
        check("reset_dout",  32'(dout_f[31:0]), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            mm_f[vecs[v].idx*2 +: 2] = vecs[v].mm;
            xfer(vecs[v].idx, vecs[v].tx, vecs[v].stx, lat, edges, sslow, glitch, timeout);
            check($sformatf("v%0d_timeout", v), 32'(timeout), 32'h0);
            check($sformatf("v%0d_data", v), 32'(dout_f[vecs[v].idx*8 +: 8]), 32'(vecs[v].exp_d));
            if (vecs[v].chk_s)
                check($sformatf("v%0d_slave", v), 32'(sdout_f[vecs[v].idx*8 +: 8]),
                      32'(vecs[v].exp_s));
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_edges", v), 32'(edges), 32'd16);
            check($sformatf("v%0d_ss_low", v), 32'(sslow), 32'(vecs[v].exp_lat - 1));
            check($sformatf("v%0d_sck_glitch", v), 32'(glitch), 32'h0);
            check($sformatf("v%0d_idle_sck", v), 32'(sck_v[vecs[v].idx]),
                  32'(CPOL_V[vecs[v].idx]));
            check($sformatf("v%0d_idle_busy", v), 32'(busy_v[vecs[v].idx]), 32'h0);
        end

        // start held high: back-to-back words, data_in change mid-word ignored
        mm_f[1:0] = 2'd0;
        @(negedge clk);
        din_f[7:0] = 8'h96;
        start_v[0] = 1'b1;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 4) din_f[7:0] = 8'h3B;
            if (done_v[0]) begin got = 1; break; end
        end
        check("held_first_done", 32'(got), 32'h1);
        check("held_first_data", 32'(dout_f[7:0]), 32'h96);
        check("held_busy_at_done", 32'(busy_v[0]), 32'h0);
        gap = 0; got = 0;
        for (int k = 0; k < 50; k++) begin
            if (!ss_v[0]) begin got = 1; break; end
            gap++;
            @(negedge clk);
        end
        check("held_restart", 32'(got), 32'h1);
        check("held_ss_gap", 32'(gap), 32'd3);
        cnt = 0; got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            cnt++;
            if (done_v[0]) begin got = 1; break; end
        end
        start_v[0] = 1'b0;
        check("held_second_done", 32'(got), 32'h1);
        check("held_second_len", 32'(cnt), 32'd36);
        check("held_second_data", 32'(dout_f[7:0]), 32'h3B);
        repeat (8) @(negedge clk);

        // reset at the 5th SCK edge aborts the word
        @(negedge clk);
        din_f[7:0] = 8'hF0;
        start_v[0] = 1'b1;
        psck  = sck_v[0];
        edges = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) start_v[0] = 1'b0;
            if (sck_v[0] != psck) edges++;
            psck = sck_v[0];
            if (edges == 5) break;
        end
        check("abort_edges_seen", 32'(edges), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ss",   32'(ss_v[0]),      32'h1);
        check("abort_sck",  32'(sck_v[0]),     32'h0);
        check("abort_busy", 32'(busy_v[0]),    32'h0);
        check("abort_dout", 32'(dout_f[7:0]),  32'h0);
        check("abort_done", 32'(done_v[0]),    32'h0);
        rst = 1'b0;
        saw_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_v[0]) saw_done = 1;
        end
        check("abort_no_done", 32'(saw_done), 32'h0);
        xfer(0, 8'h5C, 8'h00, lat, edges, sslow, glitch, timeout);
        check("after_abort_timeout", 32'(timeout), 32'h0);
        check("after_abort_data", 32'(dout_f[7:0]), 32'h5C);
        check("after_abort_latency", 32'(lat), 32'd37);
        check("after_abort_edges", 32'(edges), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
Single-clock SPI master that drives the SS/SCK/MOSI lines of the team's SPI slave and captures its MISO reply. It runs in the system clock domain and generates SCK by integer division. It supports all four CPOL/CPHA modes and shifts LSB first to match the slave's bit order. One start pulse runs one full-duplex word transfer, with a busy/done handshake to the host logic.

Parameters:
DATA_LENGTH, 8, word width in bits; legal range 2..8, since the slave counter is 3 bits.
CPOL, 0, SCK idle level; must match the attached slave.
CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge.
CLK_DIV, 2, clk cycles per SCK half-period; must be >= 2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a transfer; accepted only in IDLE.
data_in  input  DATA_LENGTH  word to transmit; latched on the accepted start.
MISO  input  1  serial data from the slave.
SS  output  1  slave select, active low.
SCK  output  1  serial clock.
MOSI  output  1  serial data to the slave.
data_out  output  DATA_LENGTH  last received word.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when data_out is updated.

Behaviour:
- All outputs are registered. No combinational path runs from any input to any output.
- Reset values: SS=1, SCK=CPOL, MOSI=0, data_out=0, busy=0, done=0. The FSM goes to IDLE and all counters clear. Reset mid-transfer aborts immediately; no done pulse is generated.
- FSM states: IDLE, SETUP, XFER, HOLD, GAP. A divider counter counts 0..CLK_DIV-1; each state advances when the counter wraps.
- IDLE:
  - SS=1, SCK=CPOL, MOSI=0.
  - On start=1, latch data_in into tx_sr, clear rx_sr, go to SETUP.
  - In the next cycle SS=0 and busy=1.
- SETUP (CLK_DIV cycles):
  - SS low, SCK=CPOL.
  - CPHA=0: MOSI=tx_sr[0] from the first SETUP cycle.
  - CPHA=1: MOSI holds 0 until the first edge.
- XFER:
  - SCK toggles every CLK_DIV cycles, giving 2*DATA_LENGTH edges. An edge counter counts 0..2*DATA_LENGTH-1.
  - The sample edge is the leading edge for CPHA=0 and the trailing edge for CPHA=1. On the clk edge that produces a sample edge, rx_sr shifts right with MISO entering the MSB, so the first received bit ends in bit 0.
  - The shift edge is the trailing edge for CPHA=0 and the leading edge for CPHA=1. On the clk edge that produces a shift edge, MOSI takes the next tx_sr bit, LSB first.
  - CPHA=0: no MOSI update on the final trailing edge; MOSI holds its last bit.
  - After the last edge, SCK=CPOL. Go to HOLD.
- HOLD (CLK_DIV cycles):
  - SS low, SCK=CPOL.
  - On exit, SS=1, data_out<=rx_sr and done=1 for exactly one cycle. busy drops in the same cycle as done.
- GAP (CLK_DIV cycles):
  - SS high. start is ignored.
  - Then go to IDLE. This guarantees the slave sees SS high for at least one half-period between words.
- start while not in IDLE: ignored; there is no queueing.
- data_in changes after acceptance have no effect.
- Latency, with start sampled at cycle N: done is high at cycle N+1+(2*DATA_LENGTH+2)*CLK_DIV.
  - Defaults give done at N+37.
  - The earliest next accepted start is CLK_DIV cycles after done.
- SCK never glitches. SCK edges occur only while SS=0, and SCK=CPOL whenever SS transitions.

Test Plan:
- Mode 0 loopback (MISO tied to MOSI), data_in=8'hA5, CLK_DIV=2 -> data_out=8'hA5, done at start+37, exactly 16 SCK edges, SS low for 36 cycles.
- Mode 0 against the slave model with slave data_in=8'h3C, master data_in=8'hC3 -> master data_out=8'h3C, slave data_out=8'hC3, MOSI bit order LSB first (1,1,0,0,0,0,1,1).
- Repeat the slave exchange for CPOL/CPHA = 01, 10, 11 with words 8'h81 and 8'h7E -> both sides correct; SCK idles at CPOL; sampling lands on the mode's specified edge.
- start held high continuously -> transfers separated by SS high for at least CLK_DIV cycles; start pulses during busy are dropped; the second word uses the data_in value sampled in IDLE.
- rst asserted at the 5th SCK edge -> next cycle SS=1, SCK=CPOL, busy=0, data_out=0, no done; a new start then completes normally.
- CLK_DIV=4, data_in=8'h00, MISO held at 1 -> data_out=8'hFF, done at start+73.
